adder_arbiter: RTL and testbench
================================

# adder_arbiter

Time-shares one pipelined 31-bit adder core (a, b, clk, ce → s, fixed latency) between several audio-path requesters. Round-robin arbitration picks one request per cycle, registers its operands into the core, and tags the operation with the requester ID. Each result returns to its requester with a one-cycle valid strobe. Sits between the per-channel mixing/accumulate logic and the shared adder wrapper inside the peripheral.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 31, operand/result width; must match the adder core
- ADD_LAT, 2, adder core latency in ce-enabled cycles, from a/b sampled to s valid

Ports:
- clk  in  1  single clock; all logic on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  global enable; 0 freezes the whole pipeline
- req_valid  in  NUM_REQ  per-requester request
- req_a  in  NUM_REQ*DATA_W  operand a; requester i occupies bits [i*DATA_W +: DATA_W]
- req_b  in  NUM_REQ*DATA_W  operand b; same packing as req_a
- req_ready  out  NUM_REQ  one-hot grant, combinational
- add_a  out  DATA_W  registered operand to core
- add_b  out  DATA_W  registered operand to core
- add_ce  out  1  core clock enable
- add_s  in  DATA_W  core sum
- rsp_valid  out  NUM_REQ  one-hot result strobe, registered
- rsp_data  out  DATA_W  result, registered; shared by all requesters
- busy  out  1  any operation in flight

## Operation
- Arbitration: round-robin. Search starts at (last_grant+1) mod NUM_REQ. The first requester found with req_valid=1 gets req_ready=1. If en=0, req_ready=0.
- Handshake: transfer happens when req_valid[i] & req_ready[i]. A requester keeps req_valid and operands stable until granted. Zero or one grant per cycle.
- last_grant updates only on a transfer. Reset value is NUM_REQ-1, so requester 0 wins first.
- Issue stage: on transfer, the granted operands are registered into add_a/add_b. Tag pipeline stage 0 loads {valid=1, id=i}. With no transfer, stage 0 loads valid=0; add_a/add_b hold their values.
- Tag pipeline: ADD_LAT+1 stages of {valid, id[clog2(NUM_REQ)-1:0]}. Shifts only when en=1, aligned with the adder pipeline.
- Response: when the last tag stage is valid and en=1, on the next edge:
  - rsp_data ← add_s
  - rsp_valid ← onehot(id)
  - rsp_valid otherwise 0; rsp_data holds.
- Arithmetic: the block does not modify the sum. Overflow wraps modulo 2^DATA_W, as in the core. No saturation.
- add_ce = en. en=0 freezes the core, the tag pipeline, last_grant, and add_a/add_b. rsp_valid goes 0 while frozen. In-flight operations resume intact when en returns to 1.
- busy = OR of all tag valid bits.
- Reset (any time, including mid-operation):
  - all tag valids, rsp_valid, rsp_data, add_a, add_b cleared to 0
  - last_grant ← NUM_REQ-1
  - in-flight results are discarded; no rsp_valid for them after reset.
- No backpressure on responses: a requester must accept rsp_valid in the cycle it is asserted.

## Timing
- Transfer in cycle T, en held 1: add_a/add_b valid from T+1. add_s valid at T+1+ADD_LAT. rsp_valid/rsp_data asserted in cycle T+2+ADD_LAT for exactly one cycle. With the default ADD_LAT=2, rsp_valid comes 4 cycles after the transfer.
- Each cycle of en=0 extends the latency by one cycle.
- Throughput: one operation per cycle sustained. Back-to-back grants go to different requesters whenever more than one is requesting.
- Responses come out in issue order.
- A requester may request again in the cycle after its grant, with its previous results still in flight.

## Structure
- Shared package adder_arb_pkg holds:
  - default constants NUM_REQ_DEF=4, DATA_W_DEF=31, ADD_LAT_DEF=2
  - tag struct typedef {logic valid; logic [ID_W-1:0] id;}
  - function onehot(id)
- One sub-module: rr_arbiter (parameter N; ports req, advance, grant). Purely combinational grant plus the registered last_grant pointer. Reusable for other shared cores in the peripheral.
- The bench drives the adder core through its existing wrapper. Model: s = a+b mod 2^31, delay ADD_LAT, gated by ce.

## Test plan
- Single request: req 2 with a=100, b=23 at cycle T → rsp_valid=4'b0100, rsp_data=123 at T+4; no other rsp_valid pulses.
- Fairness: all four requesters hold valid for 8 cycles → grant order 0,1,2,3,0,1,2,3. Responses arrive in the same order, each sum correct, one per cycle.
- Wrap-around: a=0x7FFFFFFF, b=1 → rsp_data=0.
- Enable stall: en=0 for 3 cycles starting 1 cycle after a grant → add_ce=0 during the stall, no rsp_valid while en=0, rsp_valid arrives at T+7 with the correct sum.
- Reset mid-flight: assert rst_n=0 one cycle after two back-to-back grants → all outputs 0 immediately, no responses after release, the next request is granted to requester 0 first.
- Skip idle: only requesters 1 and 3 valid → grants alternate 1,3,1,3; req_ready[0] and req_ready[2] never asserted.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// Shared constants, tag type and helpers for the adder time-sharing arbiter.
package adder_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 31;
    localparam int ADD_LAT_DEF = 2;

    // Tag id is sized for the largest supported requester count (8).
    localparam int MAX_REQ = 8;
    localparam int ID_W    = $clog2(MAX_REQ);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    function automatic logic [MAX_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        logic [MAX_REQ-1:0] r;
        r     = '0;
        r[id] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Requester-side request/response bundle of the adder arbiter.
interface adder_arbiter_if
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/adder_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, registered last-grant pointer
// that only moves when the caller reports a completed transfer.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] r_last;
    logic [IW-1:0] w_grant_id;
    logic [IW-1:0] w_idx;
    logic          w_found;
    int            w_idx_int;

    // Search starts one past the last winner and wraps modulo N.
    always_comb begin
        grant      = '0;
        w_grant_id = r_last;
        w_found    = 1'b0;
        w_idx_int  = 0;
        w_idx      = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx_int = int'(r_last) + k;
            if (w_idx_int >= N) begin
                w_idx_int = w_idx_int - N;
            end
            w_idx = IW'(w_idx_int);
            if (!w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_grant_id   = w_idx;
                w_found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= IW'(N - 1);
        end else if (advance) begin
            r_last <= w_grant_id;
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Time-shares one pipelined adder core among NUM_REQ requesters; a tag pipeline
// running in lockstep with the core routes each sum back to its requester.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADD_LAT = ADD_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    adder_arbiter_if.slave    bus,
    output logic [DATA_W-1:0] add_a,
    output logic [DATA_W-1:0] add_b,
    output logic              add_ce,
    input  logic [DATA_W-1:0] add_s,
    output logic              busy
);
    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_xfer;
    logic [ID_W-1:0]    w_gnt_id;
    logic [DATA_W-1:0]  w_sel_a;
    logic [DATA_W-1:0]  w_sel_b;
    logic [MAX_REQ-1:0] w_rsp_oh;
    logic [ADD_LAT:0]   w_tag_valid;

    tag_t               r_tag [ADD_LAT+1];
    logic [DATA_W-1:0]  r_add_a;
    logic [DATA_W-1:0]  r_add_b;
    logic [DATA_W-1:0]  r_rsp_data;
    logic [NUM_REQ-1:0] r_rsp_valid;

    // Masking requests with en yields no grant and no pointer movement while frozen.
    assign w_req = en ? bus.req_valid : '0;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (w_req),
        .advance (w_xfer),
        .grant   (w_grant)
    );

    assign w_xfer        = |w_grant;
    assign bus.req_ready = w_grant;

    always_comb begin
        w_gnt_id = '0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_gnt_id = ID_W'(i);
                w_sel_a  = bus.req_a[i*DATA_W +: DATA_W];
                w_sel_b  = bus.req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_add_a <= '0;
            r_add_b <= '0;
            for (int k = 0; k <= ADD_LAT; k++) begin
                r_tag[k] <= '0;
            end
        end else if (en) begin
            if (w_xfer) begin
                r_add_a <= w_sel_a;
                r_add_b <= w_sel_b;
            end
            r_tag[0] <= tag_t'{valid: w_xfer, id: w_gnt_id};
            for (int k = 1; k <= ADD_LAT; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    // The last tag stage lines up with add_s of the same operation.
    assign w_rsp_oh = onehot(r_tag[ADD_LAT].id);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else if (en && r_tag[ADD_LAT].valid) begin
            r_rsp_valid <= w_rsp_oh[NUM_REQ-1:0];
            r_rsp_data  <= add_s;
        end else begin
            r_rsp_valid <= '0;
        end
    end

    generate
        if (NUM_REQ < MAX_REQ) begin : g_oh_pad
            logic w_oh_unused;
            assign w_oh_unused = |w_rsp_oh[MAX_REQ-1:NUM_REQ];
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi <= ADD_LAT; gi++) begin : g_busy
            assign w_tag_valid[gi] = r_tag[gi].valid;
        end
    endgenerate

    assign busy          = |w_tag_valid;
    assign add_a         = r_add_a;
    assign add_b         = r_add_b;
    assign add_ce        = en;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: stimulus pushes expected responses to a
// scoreboard, an independent monitor pops and checks every rsp_valid pulse.
module tb_adder_arbiter;
    localparam int NR = 4;
    localparam int DW = 31;
    localparam int AL = 2;

    typedef struct {
        int            id;
        logic [DW-1:0] s;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [DW-1:0] add_a;
    logic [DW-1:0] add_b;
    logic [DW-1:0] add_s;
    logic          add_ce;
    logic          busy;

    adder_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

    adder_arbiter #(
        .NUM_REQ (NR),
        .DATA_W  (DW),
        .ADD_LAT (AL)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .bus    (bus.slave),
        .add_a  (add_a),
        .add_b  (add_b),
        .add_ce (add_ce),
        .add_s  (add_s),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Adder core wrapper model: s = a+b mod 2^31, AL ce-enabled stages.
    logic [DW-1:0] core_p [AL];
    always @(posedge clk) begin
        if (add_ce) begin
            core_p[0] <= add_a + add_b;
            for (int k = 1; k < AL; k++) begin
                core_p[k] <= core_p[k-1];
            end
        end
    end
    assign add_s = core_p[AL-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            checks   = 0;
    int            failures = 0;
    exp_t          sb [$];
    exp_t          m_exp;
    logic [DW-1:0] rs [NR];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic set_ops(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] s);
        bus.req_a[id*DW +: DW] = a;
        bus.req_b[id*DW +: DW] = b;
        rs[id] = s;
    endtask

    // One cycle: drive, check grant and add_ce, queue expected response lat cycles later.
    task automatic step(input logic [NR-1:0] v, input logic e, input logic [NR-1:0] exp_rdy,
                        input int lat);
        @(negedge clk);
        bus.req_valid = v;
        en            = e;
        #1;
        check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        check("add_ce", 64'(add_ce), 64'(e));
        if (lat > 0) begin
            for (int i = 0; i < NR; i++) begin
                if (exp_rdy[i]) begin
                    sb.push_back('{id: i, s: rs[i], cyc: cyc + lat});
                    $display("issue  cyc=%0d id=%0d exp_sum=0x%0h", cyc, i, rs[i]);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step('0, 1'b1, '0, 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        check({tag, "_rsp_data"},  64'(bus.rsp_data),  64'd0);
        check({tag, "_add_a"},     64'(add_a),         64'd0);
        check({tag, "_add_b"},     64'(add_b),         64'd0);
        check({tag, "_busy"},      64'(busy),          64'd0);
    endtask

    // Monitor: every rsp_valid pulse must match the head of the scoreboard.
    initial begin
        logic [NR-1:0] oh;
        forever begin
            @(negedge clk);
            #2;
            if (bus.rsp_valid !== '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 64'(bus.rsp_valid), 64'd0);
                end else begin
                    m_exp = sb.pop_front();
                    oh    = NR'(1) << m_exp.id;
                    check("rsp_valid", 64'(bus.rsp_valid), 64'(oh));
                    check("rsp_data",  64'(bus.rsp_data),  64'(m_exp.s));
                    check("rsp_cycle", 64'(cyc),           64'(m_exp.cyc));
                    $display("rsp    cyc=%0d valid=%b data=0x%0h", cyc, bus.rsp_valid, bus.rsp_data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        en            = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        for (int i = 0; i < NR; i++) rs[i] = '0;

        repeat (3) @(negedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        #1;
        check("reset_req_ready", 64'(bus.req_ready), 64'd0);

        // Fairness: all four hold valid for 8 cycles.
        set_ops(0, 31'd1000,       31'd234,        31'd1234);
        set_ops(1, 31'h12345678,   31'h11111111,   31'h23456789);
        set_ops(2, 31'd5,          31'd7,          31'd12);
        set_ops(3, 31'h40000000,   31'h3FFFFFFF,   31'h7FFFFFFF);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NR; i++) begin
                step(4'b1111, 1'b1, NR'(1) << i, 4);
            end
        end
        idle(6);

        // Single request from requester 2.
        set_ops(2, 31'd100, 31'd23, 31'd123);
        step(4'b0100, 1'b1, 4'b0100, 4);
        idle(6);

        // Wrap-around modulo 2^31.
        set_ops(1, 31'h7FFFFFFF, 31'd1, 31'd0);
        step(4'b0010, 1'b1, 4'b0010, 4);
        idle(6);

        // Enable stall of 3 cycles right after a grant: response at T+7.
        set_ops(0, 31'h1234, 31'h4321, 31'h5555);
        step(4'b0001, 1'b1, 4'b0001, 7);
        step(4'b0000, 1'b0, 4'b0000, 0);
        check("stall_busy", 64'(busy), 64'd1);
        step(4'b0000, 1'b0, 4'b0000, 0);
        step(4'b0000, 1'b0, 4'b0000, 0);
        idle(8);

        // Skip idle requesters: only 1 and 3 request.
        set_ops(1, 31'd1000,      31'd2000,      31'd3000);
        set_ops(3, 31'h0ABCDEF0,  31'h01010101,  31'h0BBDDFF1);
        step(4'b1010, 1'b1, 4'b0010, 4);
        step(4'b1010, 1'b1, 4'b1000, 4);
        step(4'b1010, 1'b1, 4'b0010, 4);
        step(4'b1010, 1'b1, 4'b1000, 4);
        idle(6);

        // Reset mid-flight: two grants in flight are discarded.
        step(4'b0011, 1'b1, 4'b0001, 0);
        step(4'b0011, 1'b1, 4'b0010, 0);
        @(negedge clk);
        rst_n         = 1'b0;
        bus.req_valid = '0;
        #1;
        check_zero_outputs("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(6);
        set_ops(0, 31'd1, 31'd2, 31'd3);
        step(4'b1111, 1'b1, 4'b0001, 4);
        idle(6);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
